// File: rtl/qam_pll_acq_ctrl.sv
// -----------------------------------------------------------------------------
// qam_pll_acq_ctrl
//
// Acquisition/tracking sequencer for the QAM carrier PLL. It watches the PLL
// phase-error stream and drives the PLL enable and loop gains. The PLL starts
// on wide-band acquisition gains and shifts to narrow-band tracking gains. The
// block then declares lock, detects loss of lock and flags acquisition failure.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous, active-high reset
//   clk_enable   in   sample strobe; counting and transitions only when high
//   start        in   level; leave IDLE and begin acquisition
//   stop         in   level; force IDLE on the next edge (ignores clk_enable)
//   phase_error  in   signed PLL phase error (Q1.15), valid with clk_enable
//   pll_enable   out  PLL enable (high in every state but IDLE)
//   kp, ki       out  PLL loop gains (unsigned Q0.18)
//   state        out  IDLE=0, ACQUIRE=1, TRACK=2, LOCKED=3
//   locked       out  high only in LOCKED
//   lock_lost    out  one-cycle pulse on TRACK/LOCKED -> ACQUIRE
//   acq_fail     out  sticky acquisition-timeout flag, cleared by next start
//
// There is no valid/ready handshake here. phase_error is sampled on every edge
// where clk_enable is high. All outputs are registers that update on the same
// edge as the state register.
// -----------------------------------------------------------------------------
module qam_pll_acq_ctrl #(
  parameter int ERR_W       = 16,
  parameter int GAIN_W      = 18,
  parameter int LOCK_THR    = 1024,
  parameter int LOCK_CNT    = 256,
  parameter int UNLOCK_CNT  = 64,
  parameter int ACQ_TIMEOUT = 4096,
  parameter int KP_ACQ      = 2621,
  parameter int KI_ACQ      = 3,
  parameter int KP_TRK      = 655,
  parameter int KI_TRK      = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clk_enable,
  input  logic                    start,
  input  logic                    stop,
  input  logic signed [ERR_W-1:0] phase_error,
  output logic                    pll_enable,
  output logic [GAIN_W-1:0]       kp,
  output logic [GAIN_W-1:0]       ki,
  output logic [1:0]              state,
  output logic                    locked,
  output logic                    lock_lost,
  output logic                    acq_fail
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_TRACK   = 2'd2,
    ST_LOCKED  = 2'd3
  } state_e;

  // Each counter is just wide enough to hold its saturation limit.
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);
  localparam int TMO_W  = $clog2(ACQ_TIMEOUT + 1);

  localparam logic [GOOD_W-1:0] GOOD_MAX  = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [BAD_W-1:0]  BAD_MAX   = BAD_W'(UNLOCK_CNT);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(UNLOCK_CNT - 1);
  localparam logic [TMO_W-1:0]  TMO_MAX   = TMO_W'(ACQ_TIMEOUT);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(ACQ_TIMEOUT - 1);

  localparam logic [ERR_W-1:0]  ERR_POS_MAX = {1'b0, {(ERR_W-1){1'b1}}};
  localparam logic [ERR_W-1:0]  ERR_NEG_MIN = {1'b1, {(ERR_W-1){1'b0}}};
  localparam logic [31:0]       LOCK_THR_U  = 32'(LOCK_THR);

  localparam logic [GAIN_W-1:0] KP_ACQ_G = GAIN_W'(KP_ACQ);
  localparam logic [GAIN_W-1:0] KI_ACQ_G = GAIN_W'(KI_ACQ);
  localparam logic [GAIN_W-1:0] KP_TRK_G = GAIN_W'(KP_TRK);
  localparam logic [GAIN_W-1:0] KI_TRK_G = GAIN_W'(KI_TRK);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  state_e              state_q, state_d;
  logic [GOOD_W-1:0]   good_q,  good_d;
  logic [BAD_W-1:0]    bad_q,   bad_d;
  logic [TMO_W-1:0]    tmo_q,   tmo_d;
  logic                acq_fail_q,   acq_fail_d;
  logic                lock_lost_q,  lock_lost_d;
  logic                pll_enable_q, pll_enable_d;
  logic                locked_q,     locked_d;
  logic [GAIN_W-1:0]   kp_q, kp_d;
  logic [GAIN_W-1:0]   ki_q, ki_d;

  // ---------------------------------------------------------------------------
  // Phase-error magnitude and in-lock qualifier
  // ---------------------------------------------------------------------------
  logic [ERR_W-1:0] err_raw;
  logic [ERR_W-1:0] err_abs;
  logic             in_lock;

  assign err_raw = phase_error;

  always_comb begin
    err_abs = err_raw;
    // The most-negative code has no positive twin, so it maps to full scale.
    if (err_raw == ERR_NEG_MIN) begin
      err_abs = ERR_POS_MAX;
    end else if (err_raw[ERR_W-1]) begin
      err_abs = (~err_raw) + ERR_W'(1);
    end
  end

  assign in_lock = (32'(err_abs) < LOCK_THR_U);

  // ---------------------------------------------------------------------------
  // Saturating increments and "reaches N on this sample" detectors
  // ---------------------------------------------------------------------------
  logic [GOOD_W-1:0] good_inc;
  logic [BAD_W-1:0]  bad_inc;
  logic [TMO_W-1:0]  tmo_inc;
  logic              good_hit;
  logic              bad_hit;
  logic              tmo_hit;

  assign good_inc = (good_q == GOOD_MAX) ? good_q : good_q + GOOD_W'(1);
  assign bad_inc  = (bad_q  == BAD_MAX)  ? bad_q  : bad_q  + BAD_W'(1);
  assign tmo_inc  = (tmo_q  == TMO_MAX)  ? tmo_q  : tmo_q  + TMO_W'(1);

  // A hit is the sample that takes a counter from N-1 to N. Once a counter
  // has saturated, further qualifying samples do not count as new hits.
  assign good_hit = in_lock  && (good_q == GOOD_LAST);
  assign bad_hit  = !in_lock && (bad_q  == BAD_LAST);
  assign tmo_hit  = (tmo_q == TMO_LAST);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    good_d      = good_q;
    bad_d       = bad_q;
    tmo_d       = tmo_q;
    acq_fail_d  = acq_fail_q;
    lock_lost_d = 1'b0;

    if (stop) begin
      // Highest priority and independent of the sample strobe. There is no
      // lock_lost pulse because this is a commanded shutdown.
      state_d = ST_IDLE;
    end else if (clk_enable) begin
      if (state_q != ST_IDLE) begin
        // good and bad runs are mutually exclusive: each sample extends one
        // run and breaks the other.
        good_d = in_lock ? good_inc : '0;
        bad_d  = in_lock ? '0 : bad_inc;
        if (state_q == ST_ACQUIRE) begin
          tmo_d = tmo_inc;
        end
      end

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d    = ST_ACQUIRE;
            acq_fail_d = 1'b0;
          end
        end
        ST_ACQUIRE: begin
          // Lock wins over a timeout that lands on the same sample.
          if (good_hit) begin
            state_d = ST_TRACK;
          end else if (tmo_hit) begin
            state_d    = ST_IDLE;
            acq_fail_d = 1'b1;
          end
        end
        ST_TRACK: begin
          if (good_hit) begin
            state_d = ST_LOCKED;
          end else if (bad_hit) begin
            state_d     = ST_ACQUIRE;
            lock_lost_d = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (bad_hit) begin
            state_d     = ST_ACQUIRE;
            lock_lost_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Every state change starts all counts afresh.
    if (state_d != state_q) begin
      good_d = '0;
      bad_d  = '0;
      tmo_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode from the next state. The outputs are registered on the same
  // edge as the state register, so they never lag it.
  // ---------------------------------------------------------------------------
  always_comb begin
    pll_enable_d = 1'b0;
    kp_d         = '0;
    ki_d         = '0;
    locked_d     = 1'b0;
    unique case (state_d)
      ST_IDLE: begin
        pll_enable_d = 1'b0;
      end
      ST_ACQUIRE: begin
        pll_enable_d = 1'b1;
        kp_d         = KP_ACQ_G;
        ki_d         = KI_ACQ_G;
      end
      ST_TRACK: begin
        pll_enable_d = 1'b1;
        kp_d         = KP_TRK_G;
        ki_d         = KI_TRK_G;
      end
      ST_LOCKED: begin
        pll_enable_d = 1'b1;
        kp_d         = KP_TRK_G;
        ki_d         = KI_TRK_G;
        locked_d     = 1'b1;
      end
      default: begin
        pll_enable_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      good_q       <= '0;
      bad_q        <= '0;
      tmo_q        <= '0;
      acq_fail_q   <= 1'b0;
      lock_lost_q  <= 1'b0;
      pll_enable_q <= 1'b0;
      locked_q     <= 1'b0;
      kp_q         <= '0;
      ki_q         <= '0;
    end else begin
      state_q      <= state_d;
      good_q       <= good_d;
      bad_q        <= bad_d;
      tmo_q        <= tmo_d;
      acq_fail_q   <= acq_fail_d;
      lock_lost_q  <= lock_lost_d;
      pll_enable_q <= pll_enable_d;
      locked_q     <= locked_d;
      kp_q         <= kp_d;
      ki_q         <= ki_d;
    end
  end

  assign state      = state_q;
  assign pll_enable = pll_enable_q;
  assign kp         = kp_q;
  assign ki         = ki_q;
  assign locked     = locked_q;
  assign lock_lost  = lock_lost_q;
  assign acq_fail   = acq_fail_q;

endmodule

// File: tb/tb_qam_pll_acq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qam_pll_acq_ctrl
//
// Bench for qam_pll_acq_ctrl with short counter limits. The driver applies one
// sample per clock on the falling edge. For each sample it asks the reference
// model for the expected registered outputs and pushes them into exp_q. The
// monitor pops one entry after each rising edge and compares it with the DUT.
// Directed sequences cover the main scenarios and boundaries. A randomized
// soak follows them.
// -----------------------------------------------------------------------------
module tb_qam_pll_acq_ctrl;

  localparam int ERR_W       = 16;
  localparam int GAIN_W      = 18;
  localparam int LOCK_THR    = 100;
  localparam int LOCK_CNT    = 8;
  localparam int UNLOCK_CNT  = 4;
  localparam int ACQ_TIMEOUT = 32;
  localparam int VW          = 2 + 1 + GAIN_W + GAIN_W + 3;

  // Reference-model modes (plain integers, named after the documented codes)
  localparam int M_IDLE = 0, M_ACQ = 1, M_TRK = 2, M_LCK = 3;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    clk_enable = 1'b0;
  logic                    start = 1'b0;
  logic                    stop = 1'b0;
  logic signed [ERR_W-1:0] phase_error = '0;
  logic                    pll_enable;
  logic [GAIN_W-1:0]       kp;
  logic [GAIN_W-1:0]       ki;
  logic [1:0]              state;
  logic                    locked;
  logic                    lock_lost;
  logic                    acq_fail;

  always #5 clk = ~clk;

  qam_pll_acq_ctrl #(
    .ERR_W(ERR_W), .GAIN_W(GAIN_W), .LOCK_THR(LOCK_THR), .LOCK_CNT(LOCK_CNT),
    .UNLOCK_CNT(UNLOCK_CNT), .ACQ_TIMEOUT(ACQ_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable), .start(start),
    .stop(stop), .phase_error(phase_error), .pll_enable(pll_enable),
    .kp(kp), .ki(ki), .state(state), .locked(locked),
    .lock_lost(lock_lost), .acq_fail(acq_fail)
  );

  // ---------------------------------------------------------------------------
  // Reference model: mode plus run lengths taken straight from the rules
  // ---------------------------------------------------------------------------
  int m_mode = M_IDLE;
  int m_good_run = 0;
  int m_bad_run = 0;
  int m_acq_samples = 0;
  bit m_fail = 1'b0;
  bit m_lost = 1'b0;

  task automatic model_reset();
    m_mode = M_IDLE;
    m_good_run = 0;
    m_bad_run = 0;
    m_acq_samples = 0;
    m_fail = 1'b0;
    m_lost = 1'b0;
  endtask

  task automatic model_step(input bit ce, input bit st, input bit sp, input int err);
    int mag;
    int nxt;
    bit good;
    nxt = m_mode;
    m_lost = 1'b0;
    if (sp) begin
      nxt = M_IDLE;
    end else if (ce) begin
      mag = (err < 0) ? -err : err;
      if (mag > 32767) mag = 32767;
      good = (mag < LOCK_THR);
      if (good) begin
        m_good_run = (m_good_run < LOCK_CNT) ? m_good_run + 1 : LOCK_CNT;
        m_bad_run = 0;
      end else begin
        m_bad_run = (m_bad_run < UNLOCK_CNT) ? m_bad_run + 1 : UNLOCK_CNT;
        m_good_run = 0;
      end
      case (m_mode)
        M_IDLE: if (st) begin nxt = M_ACQ; m_fail = 1'b0; end
        M_ACQ: begin
          m_acq_samples = (m_acq_samples < ACQ_TIMEOUT) ? m_acq_samples + 1 : ACQ_TIMEOUT;
          if (good && m_good_run == LOCK_CNT) nxt = M_TRK;
          else if (m_acq_samples == ACQ_TIMEOUT) begin nxt = M_IDLE; m_fail = 1'b1; end
        end
        M_TRK: begin
          if (good && m_good_run == LOCK_CNT) nxt = M_LCK;
          else if (!good && m_bad_run == UNLOCK_CNT) begin nxt = M_ACQ; m_lost = 1'b1; end
        end
        default: begin
          if (!good && m_bad_run == UNLOCK_CNT) begin nxt = M_ACQ; m_lost = 1'b1; end
        end
      endcase
    end
    if (nxt != m_mode) begin
      m_good_run = 0;
      m_bad_run = 0;
      m_acq_samples = 0;
    end
    m_mode = nxt;
  endtask

  function automatic logic [VW-1:0] model_vec();
    logic [GAIN_W-1:0] ekp;
    logic [GAIN_W-1:0] eki;
    ekp = '0;
    eki = '0;
    if (m_mode == M_ACQ) begin ekp = GAIN_W'(2621); eki = GAIN_W'(3); end
    if (m_mode == M_TRK || m_mode == M_LCK) begin ekp = GAIN_W'(655); eki = GAIN_W'(1); end
    return {2'(m_mode), (m_mode != M_IDLE), ekp, eki, (m_mode == M_LCK), m_lost, m_fail};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {state, pll_enable, kp, ki, locked, lock_lost, acq_fail};
  endfunction

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  logic [VW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;

  task automatic compare(input string name, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got st=%0d en=%0b kp=%0d ki=%0d lk=%0b ll=%0b af=%0b, want st=%0d en=%0b kp=%0d ki=%0d lk=%0b ll=%0b af=%0b",
               name, got[VW-1 -: 2], got[VW-3], got[VW-4 -: GAIN_W], got[GAIN_W+2 +: GAIN_W],
               got[2], got[1], got[0],
               exp[VW-1 -: 2], exp[VW-3], exp[VW-4 -: GAIN_W], exp[GAIN_W+2 +: GAIN_W],
               exp[2], exp[1], exp[0]);
    end
  endtask

  // Monitor: one registered response per rising edge that had a sample.
  initial begin
    logic [VW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        compare($sformatf("cycle_%0d", cyc), dut_vec(), e);
        cyc++;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic step(input bit ce, input bit st, input bit sp, input int err);
    @(negedge clk);
    clk_enable = ce;
    start = st;
    stop = sp;
    phase_error = ERR_W'(err);
    model_step(ce, st, sp, err);
    exp_q.push_back(model_vec());
  endtask

  task automatic run(input int n, input int err);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, err);
  endtask

  task automatic async_reset_check(input string name);
    @(negedge clk);
    #2;
    reset = 1'b1;
    model_reset();
    #1;
    compare(name, dut_vec(), model_vec());
    @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic int rand_err();
    int r;
    int b;
    r = $urandom_range(0, 99);
    if (r < 70) return $urandom_range(0, 198) - 99;
    if (r < 82) begin
      b = $urandom_range(0, 3);
      return (b == 0) ? 99 : (b == 1) ? -99 : (b == 2) ? 100 : -100;
    end
    if (r < 94) return $urandom_range(0, 65535) - 32768;
    return -32768;
  endfunction

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    #3;
    model_reset();
    compare("reset_state", dut_vec(), model_vec());
    @(negedge clk);
    reset = 1'b0;

    // Clean acquisition: ACQUIRE, TRACK after 8, LOCKED after 8 more
    step(1'b1, 1'b1, 1'b0, 0);
    run(LOCK_CNT, 0);
    run(LOCK_CNT, 0);

    // Isolated bad samples keep LOCKED; 4 full-scale negatives lose lock
    run(3, 500);
    run(1, 0);
    run(UNLOCK_CNT, -32768);
    run(2, 0);

    // Timeout with alternating good/bad, sticky flag, cleared by next start
    step(1'b1, 1'b0, 1'b1, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 1; i <= ACQ_TIMEOUT; i++) step(1'b1, 1'b0, 1'b0, (i % 2) ? 0 : 200);
    run(3, 0);
    step(1'b1, 1'b1, 1'b0, 0);

    // Threshold boundary: 99 good, 100 bad; lock and timeout on the same sample
    for (int i = 1; i <= ACQ_TIMEOUT - LOCK_CNT; i++) step(1'b1, 1'b0, 1'b0, (i % 2) ? 99 : 100);
    run(LOCK_CNT, -99);
    run(2, 0);

    // Sample strobe toggling during ACQUIRE
    step(1'b1, 1'b0, 1'b1, 0);
    step(1'b1, 1'b1, 1'b0, 0);
    for (int i = 0; i < 2 * LOCK_CNT; i++) step((i % 2) == 0, 1'b0, 1'b0, 0);
    step(1'b0, 1'b0, 1'b0, 0);

    // Asynchronous reset in TRACK
    run(3, 0);
    async_reset_check("reset_mid_track");

    // stop in LOCKED, with clk_enable low
    step(1'b1, 1'b1, 1'b0, 0);
    run(2 * LOCK_CNT, 0);
    step(1'b0, 1'b0, 1'b1, 0);
    run(2, 0);

    // Randomized soak
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) != 0, $urandom_range(0, 9) < 3,
           $urandom_range(0, 249) == 0, rand_err());
    end

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain: got %0d pending, want 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
